// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory request arbiter.
// Imported by the arbiter top and its starvation counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_ABORT = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_IF   = 2'd1,
        G_LD   = 2'd2,
        G_ST   = 2'd3
    } arb_grant_t;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [2:0] LEN_WORD = 3'b010;

endpackage

// File: rtl/mem_arb_age.sv
// Saturating starvation counter for the fetch requester.
// Boost asserts once enough non-fetch grants passed fetch by.
module mem_arb_age
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_boost
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] r_cnt;

    // Clear wins over increment; count saturates at 15.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (i_clr) begin
                r_cnt <= '0;
            end else if (i_inc && (r_cnt != 4'hF)) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    assign o_boost = (r_cnt >= LIMIT);

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates fetch, load and committed-store traffic onto one
// memory controller; one transaction in flight, flush-aware.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic        if_valid,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_data,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  ld_size,
    output logic        ld_ready,
    output logic [31:0] ld_data,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [2:0]  st_size,
    input  logic [31:0] st_data,
    output logic        st_ready,
    output logic        mc_valid,
    output logic        mc_wr,
    output logic [31:0] mc_addr,
    output logic [2:0]  mc_len,
    output logic [31:0] mc_data,
    output logic        mc_abort,
    input  logic        mc_ready,
    input  logic [31:0] mc_res
);

    arb_state_t  r_state, w_nxt_state;
    arb_grant_t  r_grant, w_nxt_grant, w_pick;
    logic        r_mc_valid, w_nxt_valid;
    logic        r_mc_wr, w_nxt_wr;
    logic [31:0] r_mc_addr, w_nxt_addr;
    logic [2:0]  r_mc_len, w_nxt_len;
    logic [31:0] r_mc_data, w_nxt_data;
    logic        r_mc_abort, w_nxt_abort;
    logic        w_inc, w_clr, w_boost, w_done;

    mem_arb_age #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_age (
        .i_clk   (clk_in),
        .i_rst   (rst_in),
        .i_en    (rdy_in),
        .i_inc   (w_inc),
        .i_clr   (w_clr),
        .o_boost (w_boost)
    );

    // Priority select: a flush leaves only the committed store eligible.
    always_comb begin
        w_pick = G_NONE;
        if (rob_clear) begin
            if (st_valid) w_pick = G_ST;
        end else if (w_boost && if_valid) begin
            w_pick = G_IF;
        end else if (st_valid) begin
            w_pick = G_ST;
        end else if (ld_valid) begin
            w_pick = G_LD;
        end else if (if_valid) begin
            w_pick = G_IF;
        end
    end

    // Next-state, grant, controller registers and age control.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_grant = r_grant;
        w_nxt_valid = r_mc_valid;
        w_nxt_wr    = r_mc_wr;
        w_nxt_addr  = r_mc_addr;
        w_nxt_len   = r_mc_len;
        w_nxt_data  = r_mc_data;
        w_nxt_abort = 1'b0;
        w_inc       = 1'b0;
        w_clr       = !if_valid;
        unique case (r_state)
            S_IDLE: begin
                if (rob_clear) w_clr = 1'b1;
                if (w_pick != G_NONE) begin
                    w_nxt_state = S_BUSY;
                    w_nxt_grant = w_pick;
                    w_nxt_valid = 1'b1;
                    if (w_pick == G_IF) w_clr = 1'b1;
                    else if (if_valid)  w_inc = 1'b1;
                end
                unique case (w_pick)
                    G_IF: begin
                        w_nxt_wr   = 1'b0;
                        w_nxt_addr = if_addr;
                        w_nxt_len  = LEN_WORD;
                        w_nxt_data = '0;
                    end
                    G_LD: begin
                        w_nxt_wr   = 1'b0;
                        w_nxt_addr = ld_addr;
                        w_nxt_len  = ld_size;
                        w_nxt_data = '0;
                    end
                    G_ST: begin
                        w_nxt_wr   = 1'b1;
                        w_nxt_addr = st_addr;
                        w_nxt_len  = st_size;
                        w_nxt_data = st_data;
                    end
                    default: ;
                endcase
            end
            S_BUSY: begin
                if (rob_clear && (r_grant != G_ST)) begin
                    w_nxt_state = S_ABORT;
                    w_nxt_grant = G_NONE;
                    w_nxt_valid = 1'b0;
                    w_nxt_abort = 1'b1;
                end else if (mc_ready) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_grant = G_NONE;
                    w_nxt_valid = 1'b0;
                end
            end
            S_ABORT: begin
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_grant = G_NONE;
                w_nxt_valid = 1'b0;
            end
        endcase
    end

    // State and controller registers; everything freezes while rdy_in is low.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            r_grant    <= G_NONE;
            r_mc_valid <= 1'b0;
            r_mc_wr    <= 1'b0;
            r_mc_addr  <= '0;
            r_mc_len   <= '0;
            r_mc_data  <= '0;
            r_mc_abort <= 1'b0;
        end else if (rdy_in) begin
            r_state    <= w_nxt_state;
            r_grant    <= w_nxt_grant;
            r_mc_valid <= w_nxt_valid;
            r_mc_wr    <= w_nxt_wr;
            r_mc_addr  <= w_nxt_addr;
            r_mc_len   <= w_nxt_len;
            r_mc_data  <= w_nxt_data;
            r_mc_abort <= w_nxt_abort;
        end
    end

    assign w_done   = mc_ready && (r_state == S_BUSY) && rdy_in;
    assign if_ready = w_done && (r_grant == G_IF) && !rob_clear;
    assign ld_ready = w_done && (r_grant == G_LD) && !rob_clear;
    assign st_ready = w_done && (r_grant == G_ST);
    assign if_data  = mc_res;
    assign ld_data  = mc_res;

    assign mc_valid = r_mc_valid;
    assign mc_wr    = r_mc_wr;
    assign mc_addr  = r_mc_addr;
    assign mc_len   = r_mc_len;
    assign mc_data  = r_mc_data;
    assign mc_abort = r_mc_abort;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed and randomized bench for mem_req_arbiter.
// Grant order predicted from a plain starvation-count model.
module tb_mem_req_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, rob_clear;
    logic        if_valid, if_ready;
    logic [31:0] if_addr, if_data;
    logic        ld_valid, ld_ready;
    logic [31:0] ld_addr, ld_data;
    logic [2:0]  ld_size;
    logic        st_valid, st_ready;
    logic [31:0] st_addr, st_data;
    logic [2:0]  st_size;
    logic        mc_valid, mc_wr, mc_abort, mc_ready;
    logic [31:0] mc_addr, mc_data, mc_res;
    logic [2:0]  mc_len;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_req_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .rob_clear(rob_clear),
        .if_valid(if_valid), .if_addr(if_addr),
        .if_ready(if_ready), .if_data(if_data),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size),
        .ld_ready(ld_ready), .ld_data(ld_data),
        .st_valid(st_valid), .st_addr(st_addr), .st_size(st_size),
        .st_data(st_data), .st_ready(st_ready),
        .mc_valid(mc_valid), .mc_wr(mc_wr), .mc_addr(mc_addr),
        .mc_len(mc_len), .mc_data(mc_data), .mc_abort(mc_abort),
        .mc_ready(mc_ready), .mc_res(mc_res)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random-phase state: who is waiting, and the fetch starvation count.
    int          cnt_m;
    int          win;
    int          dly;
    logic [31:0] res;
    logic [2:0]  exp_len;
    logic [31:0] exp_addr;

    initial begin
        rst = 1'b1; rdy = 1'b1; rob_clear = 1'b0;
        if_valid = 1'b0; if_addr = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_size = '0;
        st_valid = 1'b0; st_addr = '0; st_size = '0; st_data = '0;
        mc_ready = 1'b0; mc_res = '0;
        tick();
        tick();
        chk("rst mc_valid", mc_valid, 0);
        chk("rst mc_wr", mc_wr, 0);
        chk("rst mc_addr", mc_addr, 0);
        chk("rst mc_len", mc_len, 0);
        chk("rst mc_data", mc_data, 0);
        chk("rst mc_abort", mc_abort, 0);
        chk("rst readies", {if_ready, ld_ready, st_ready}, 0);
        rst = 1'b0;

        // Single fetch with a 5-cycle controller latency.
        if_valid = 1'b1; if_addr = 32'h100;
        tick();
        chk("fetch mc_valid", mc_valid, 1);
        chk("fetch mc_addr", mc_addr, 32'h100);
        chk("fetch mc_len", mc_len, 3'b010);
        chk("fetch mc_wr", mc_wr, 0);
        repeat (5) tick();
        chk("fetch hold", mc_valid, 1);
        chk("fetch early ready", if_ready, 0);
        mc_ready = 1'b1; mc_res = 32'hDEADBEEF;
        #1;
        chk("fetch if_ready", if_ready, 1);
        chk("fetch if_data", if_data, 32'hDEADBEEF);
        tick();
        mc_ready = 1'b0; if_valid = 1'b0;
        #1;
        chk("fetch ready pulse", if_ready, 0);
        chk("fetch done valid", mc_valid, 0);

        // All three at once: store, then load, then fetch.
        st_valid = 1'b1; st_addr = 32'h200; st_size = 3'b010;
        st_data = 32'h1234_5678;
        ld_valid = 1'b1; ld_addr = 32'h300; ld_size = 3'b001;
        if_valid = 1'b1; if_addr = 32'h400;
        tick();
        chk("prio st addr", mc_addr, 32'h200);
        chk("prio st wr", mc_wr, 1);
        chk("prio st data", mc_data, 32'h1234_5678);
        mc_ready = 1'b1;
        #1;
        chk("prio st_ready", st_ready, 1);
        chk("prio ld_ready idle", ld_ready, 0);
        tick();
        mc_ready = 1'b0; st_valid = 1'b0;
        chk("prio bubble", mc_valid, 0);
        tick();
        chk("prio ld valid", mc_valid, 1);
        chk("prio ld addr", mc_addr, 32'h300);
        chk("prio ld len", mc_len, 3'b001);
        mc_ready = 1'b1; mc_res = 32'h0000_BEEF;
        #1;
        chk("prio ld_ready", ld_ready, 1);
        chk("prio ld_data", ld_data, 32'h0000_BEEF);
        tick();
        mc_ready = 1'b0; ld_valid = 1'b0;
        tick();
        chk("prio if addr", mc_addr, 32'h400);
        mc_ready = 1'b1; mc_res = 32'hCAFE_0001;
        #1;
        chk("prio if_ready", if_ready, 1);
        tick();
        mc_ready = 1'b0; if_valid = 1'b0;

        // Starvation guard: fetch wins after exactly four loads.
        ld_valid = 1'b1; ld_addr = 32'h500; ld_size = 3'b010;
        if_valid = 1'b1; if_addr = 32'h600;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("starve ld grant %0d", k), mc_addr, 32'h500);
            mc_ready = 1'b1;
            tick();
            mc_ready = 1'b0;
        end
        tick();
        chk("starve if boosted", mc_addr, 32'h600);
        mc_ready = 1'b1;
        #1;
        chk("starve if_ready", if_ready, 1);
        tick();
        mc_ready = 1'b0; ld_valid = 1'b0; if_valid = 1'b0;

        // Flush during a load, completion in the same cycle.
        ld_valid = 1'b1; ld_addr = 32'h700; ld_size = 3'b000;
        tick();
        chk("flush ld grant", mc_addr, 32'h700);
        rob_clear = 1'b1; mc_ready = 1'b1;
        #1;
        chk("flush ld_ready", ld_ready, 0);
        tick();
        rob_clear = 1'b0; mc_ready = 1'b0; ld_valid = 1'b0;
        chk("flush abort", mc_abort, 1);
        chk("flush valid", mc_valid, 0);
        if_valid = 1'b1; if_addr = 32'h800;
        tick();
        chk("flush abort drop", mc_abort, 0);
        chk("flush no grant", mc_valid, 0);
        tick();
        chk("flush idle grant", mc_valid, 1);
        chk("flush idle addr", mc_addr, 32'h800);
        mc_ready = 1'b1;
        tick();
        mc_ready = 1'b0; if_valid = 1'b0;

        // Flush during a committed store is ignored.
        st_valid = 1'b1; st_addr = 32'h30000; st_size = 3'b000;
        st_data = 32'h41;
        tick();
        rob_clear = 1'b1;
        tick();
        rob_clear = 1'b0;
        chk("st flush valid", mc_valid, 1);
        chk("st flush addr", mc_addr, 32'h30000);
        chk("st flush data", mc_data, 32'h41);
        chk("st flush len", mc_len, 3'b000);
        chk("st flush abort", mc_abort, 0);
        rob_clear = 1'b1; mc_ready = 1'b1;
        #1;
        chk("st flush ready", st_ready, 1);
        tick();
        rob_clear = 1'b0; mc_ready = 1'b0; st_valid = 1'b0;
        chk("st flush done abort", mc_abort, 0);
        chk("st flush done valid", mc_valid, 0);

        // rdy_in low freezes everything, even with mc_ready high.
        ld_valid = 1'b1; ld_addr = 32'h900; ld_size = 3'b101;
        tick();
        chk("frz len", mc_len, 3'b101);
        rdy = 1'b0; mc_ready = 1'b1; mc_res = 32'h0000_55AA;
        #1;
        chk("frz ld_ready", ld_ready, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("frz valid %0d", k), mc_valid, 1);
            chk($sformatf("frz ready %0d", k), ld_ready, 0);
        end
        rdy = 1'b1;
        #1;
        chk("frz resume ready", ld_ready, 1);
        chk("frz resume data", ld_data, 32'h0000_55AA);
        tick();
        mc_ready = 1'b0; ld_valid = 1'b0;
        chk("frz done", mc_valid, 0);

        // Flush in IDLE blocks a fetch grant for that cycle.
        if_valid = 1'b1; if_addr = 32'hA00; rob_clear = 1'b1;
        tick();
        rob_clear = 1'b0;
        chk("idle flush no grant", mc_valid, 0);
        tick();
        chk("idle flush then grant", mc_valid, 1);

        // Asynchronous reset mid-transaction.
        mc_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("arst valid", mc_valid, 0);
        chk("arst addr", mc_addr, 0);
        chk("arst if_ready", if_ready, 0);
        mc_ready = 1'b0; if_valid = 1'b0;
        tick();
        rst = 1'b0;

        // Randomized traffic against the starvation-count model.
        cnt_m = 0;
        for (int n = 0; n < 80; n++) begin
            if (!st_valid && $urandom_range(0, 1) == 1) begin
                st_valid = 1'b1; st_addr = $urandom; st_data = $urandom;
                st_size = {1'b0, 2'($urandom_range(0, 2))};
            end
            if (!ld_valid && $urandom_range(0, 1) == 1) begin
                ld_valid = 1'b1; ld_addr = $urandom;
                ld_size = {1'($urandom_range(0, 1)),
                           2'($urandom_range(0, 2))};
            end
            if (!if_valid && $urandom_range(0, 1) == 1) begin
                if_valid = 1'b1; if_addr = $urandom;
            end
            if (!if_valid && !ld_valid && !st_valid) begin
                ld_valid = 1'b1; ld_addr = $urandom; ld_size = 3'b010;
            end
            if (if_valid && cnt_m >= 4) win = 1;
            else if (st_valid)          win = 3;
            else if (ld_valid)          win = 2;
            else                        win = 1;
            tick();
            if (!if_valid || win == 1) cnt_m = 0;
            else if (cnt_m < 15)      cnt_m = cnt_m + 1;
            exp_addr = (win == 1) ? if_addr : (win == 2) ? ld_addr : st_addr;
            exp_len  = (win == 1) ? 3'b010  : (win == 2) ? ld_size : st_size;
            chk("rnd valid", mc_valid, 1);
            chk("rnd addr", mc_addr, exp_addr);
            chk("rnd len", mc_len, exp_len);
            chk("rnd wr", mc_wr, (win == 3) ? 1 : 0);
            if (win == 3) chk("rnd st data", mc_data, st_data);
            dly = $urandom_range(0, 3);
            repeat (dly) tick();
            res = $urandom;
            mc_ready = 1'b1; mc_res = res;
            #1;
            chk("rnd if_ready", if_ready, (win == 1) ? 1 : 0);
            chk("rnd ld_ready", ld_ready, (win == 2) ? 1 : 0);
            chk("rnd st_ready", st_ready, (win == 3) ? 1 : 0);
            if (win == 1) chk("rnd if_data", if_data, res);
            if (win == 2) chk("rnd ld_data", ld_data, res);
            tick();
            if (!if_valid) cnt_m = 0;
            mc_ready = 1'b0;
            if (win == 1) if_valid = 1'b0;
            if (win == 2) ld_valid = 1'b0;
            if (win == 3) st_valid = 1'b0;
            chk("rnd bubble", mc_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
